// File: rtl/alif_param_programmer.sv
// Serial programmer for the dual-leak ALIF parameter loader: arm, 48 bits MSB-first, release, await params_ready.
// Optional read-back check of the loader outputs is built when PROG_VERIFY_EN is defined.
module alif_param_programmer #(
  parameter int unsigned FIELD_BITS    = 8,
  parameter int unsigned NUM_FIELDS    = 6,
  parameter int unsigned READY_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [2:0] cfg_weight_a,
  input  logic [7:0] cfg_leak_rate_1,
  input  logic [7:0] cfg_leak_rate_2,
  input  logic [7:0] cfg_threshold_min,
  input  logic [3:0] cfg_leak_cycles_1,
  input  logic [3:0] cfg_leak_cycles_2,
  output logic       ldr_load_enable,
  output logic       ldr_serial_data,
  input  logic       ldr_params_ready,
`ifdef PROG_VERIFY_EN
  input  logic [2:0] ldr_weight_a,
  input  logic [7:0] ldr_leak_rate_1,
  input  logic [7:0] ldr_leak_rate_2,
  input  logic [7:0] ldr_threshold_min,
  input  logic [3:0] ldr_leak_cycles_1,
  input  logic [3:0] ldr_leak_cycles_2,
  output logic       verify_err,
`endif
  output logic       busy,
  output logic       done,
  output logic       timeout_err
);

  localparam int unsigned SET_BITS = FIELD_BITS * NUM_FIELDS;
  localparam logic [5:0]  LAST_BIT = 6'(SET_BITS - 1);
  localparam logic [3:0]  TMO_LAST = 4'(READY_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARM      = 3'd1,
    SHIFT    = 3'd2,
    RELEASE  = 3'd3,
    WAIT_RDY = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [5:0]            cnt_q, cnt_d;
  logic [3:0]            tmo_q, tmo_d;
  logic [SET_BITS-1:0]   shadow_q, shadow_d;
  logic                  ld_en_q, ld_en_d;
  logic                  sd_q, sd_d;
  logic                  done_q, done_d;
  logic                  tmo_err_q, tmo_err_d;
  logic                  cfg_ready_q, cfg_ready_d;
  logic                  busy_q, busy_d;
  logic [SET_BITS-1:0]   cfg_set_s;

  // Narrow fields are zero-extended to a full byte so every field occupies exactly 8 serial bits.
  assign cfg_set_s = {5'b0, cfg_weight_a, cfg_leak_rate_1, cfg_leak_rate_2,
                      cfg_threshold_min, 4'b0, cfg_leak_cycles_1, 4'b0, cfg_leak_cycles_2};

`ifdef PROG_VERIFY_EN
  logic [SET_BITS-1:0] copy_q, copy_d;
  logic                vfy_err_q, vfy_err_d;
  logic                mismatch_s;

  function automatic logic set_mismatch(input logic [47:0] ref_set, input logic [2:0] wa,
                                        input logic [7:0] lr1, input logic [7:0] lr2,
                                        input logic [7:0] thm, input logic [3:0] lc1,
                                        input logic [3:0] lc2);
    return ({5'b0, wa, lr1, lr2, thm, 4'b0, lc1, 4'b0, lc2} != ref_set);
  endfunction

  assign mismatch_s = set_mismatch(copy_q, ldr_weight_a, ldr_leak_rate_1, ldr_leak_rate_2,
                                   ldr_threshold_min, ldr_leak_cycles_1, ldr_leak_cycles_2);
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    shadow_d  = shadow_q;
    ld_en_d   = ld_en_q;
    sd_d      = sd_q;
    done_d    = 1'b0;
    tmo_err_d = tmo_err_q;
`ifdef PROG_VERIFY_EN
    copy_d    = copy_q;
    vfy_err_d = vfy_err_q;
`endif
    if (enable) begin
      case (state_q)
        IDLE: begin
          if (cfg_valid) begin
            state_d   = ARM;
            shadow_d  = cfg_set_s;
            cnt_d     = 6'd0;
            tmo_d     = 4'd0;
            ld_en_d   = 1'b1;
            sd_d      = 1'b0;
            tmo_err_d = 1'b0;
`ifdef PROG_VERIFY_EN
            copy_d    = cfg_set_s;
            vfy_err_d = 1'b0;
`endif
          end else begin
            ld_en_d = 1'b0;
            sd_d    = 1'b0;
          end
        end
        ARM: begin
          state_d  = SHIFT;
          ld_en_d  = 1'b1;
          sd_d     = shadow_q[SET_BITS-1];
          shadow_d = {shadow_q[SET_BITS-2:0], 1'b0};
          cnt_d    = 6'd0;
        end
        SHIFT: begin
          // cnt_q names the bit currently on the wire; the next one is loaded on this edge.
          if (cnt_q == LAST_BIT) begin
            state_d = RELEASE;
            ld_en_d = 1'b0;
            sd_d    = 1'b0;
          end else begin
            ld_en_d  = 1'b1;
            sd_d     = shadow_q[SET_BITS-1];
            shadow_d = {shadow_q[SET_BITS-2:0], 1'b0};
            cnt_d    = cnt_q + 6'd1;
          end
        end
        RELEASE: begin
          state_d = WAIT_RDY;
          ld_en_d = 1'b0;
          sd_d    = 1'b0;
          tmo_d   = 4'd0;
        end
        WAIT_RDY: begin
          if (ldr_params_ready) begin
            state_d = IDLE;
            done_d  = 1'b1;
`ifdef PROG_VERIFY_EN
            vfy_err_d = vfy_err_q | mismatch_s;
`endif
          end else if (tmo_q == TMO_LAST) begin
            state_d   = IDLE;
            tmo_err_d = 1'b1;
          end else begin
            tmo_d = tmo_q + 4'd1;
          end
        end
        default: begin
          state_d = IDLE;
          ld_en_d = 1'b0;
          sd_d    = 1'b0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
    cfg_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  // State, datapath and registered outputs; everything except done holds while enable is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 6'd0;
      tmo_q       <= 4'd0;
      shadow_q    <= '0;
      ld_en_q     <= 1'b0;
      sd_q        <= 1'b0;
      done_q      <= 1'b0;
      tmo_err_q   <= 1'b0;
      cfg_ready_q <= 1'b1;
      busy_q      <= 1'b0;
`ifdef PROG_VERIFY_EN
      copy_q      <= '0;
      vfy_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      shadow_q    <= shadow_d;
      ld_en_q     <= ld_en_d;
      sd_q        <= sd_d;
      done_q      <= done_d;
      tmo_err_q   <= tmo_err_d;
      cfg_ready_q <= cfg_ready_d;
      busy_q      <= busy_d;
`ifdef PROG_VERIFY_EN
      copy_q      <= copy_d;
      vfy_err_q   <= vfy_err_d;
`endif
    end
  end

  assign cfg_ready       = cfg_ready_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign timeout_err     = tmo_err_q;
  assign ldr_load_enable = ld_en_q;
  assign ldr_serial_data = sd_q;
`ifdef PROG_VERIFY_EN
  assign verify_err      = vfy_err_q;
`endif

endmodule

// File: tb/tb_alif_param_programmer.sv
// Directed bench for alif_param_programmer with a behavioural serial-loader model.
module tb_alif_param_programmer;
  logic       clk = 1'b0;
  logic       reset, enable, cfg_valid;
  logic       cfg_ready, busy, done, timeout_err;
  logic [2:0] cfg_weight_a;
  logic [7:0] cfg_leak_rate_1, cfg_leak_rate_2, cfg_threshold_min;
  logic [3:0] cfg_leak_cycles_1, cfg_leak_cycles_2;
  logic       ldr_load_enable, ldr_serial_data, ldr_params_ready;
  logic       tb_hold_low = 1'b0;
  logic       tb_corrupt = 1'b0;

  int checks = 0;
  int failures = 0;

  // Loader model: arm on load_enable, then 48 bits MSB first; a drop of load_enable aborts to idle.
  logic [1:0]  m_state = 2'd0;
  logic [5:0]  m_cnt = 6'd0;
  logic [47:0] m_sr = 48'h0;
  logic        m_rdy = 1'b0;
  logic [7:0]  m_field [0:5] = '{default: 8'h00};

  always @(posedge clk) begin
    if (enable) begin
      case (m_state)
        2'd0: if (ldr_load_enable) begin m_state <= 2'd1; m_cnt <= 6'd0; m_rdy <= 1'b0; m_sr <= 48'h0; end
        2'd1: begin
          if (!ldr_load_enable) m_state <= 2'd0;
          else begin
            m_sr <= {m_sr[46:0], ldr_serial_data};
            if (m_cnt[2:0] == 3'd7) m_field[m_cnt[5:3]] <= {m_sr[6:0], ldr_serial_data};
            if (m_cnt == 6'd47) begin m_state <= 2'd2; m_rdy <= 1'b1; end
            m_cnt <= m_cnt + 6'd1;
          end
        end
        default: if (!ldr_load_enable) m_state <= 2'd0;
      endcase
    end
  end

  assign ldr_params_ready = m_rdy & ~tb_hold_low;

`ifdef PROG_VERIFY_EN
  logic [2:0] ldr_weight_a;
  logic [7:0] ldr_leak_rate_1, ldr_leak_rate_2, ldr_threshold_min;
  logic [3:0] ldr_leak_cycles_1, ldr_leak_cycles_2;
  logic       verify_err;
  assign ldr_weight_a      = m_field[0][2:0];
  assign ldr_leak_rate_1   = m_field[1];
  assign ldr_leak_rate_2   = m_field[2] ^ (tb_corrupt ? 8'h01 : 8'h00);
  assign ldr_threshold_min = m_field[3];
  assign ldr_leak_cycles_1 = m_field[4][3:0];
  assign ldr_leak_cycles_2 = m_field[5][3:0];
`endif

  alif_param_programmer dut (
    .clk(clk), .reset(reset), .enable(enable),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_weight_a(cfg_weight_a), .cfg_leak_rate_1(cfg_leak_rate_1),
    .cfg_leak_rate_2(cfg_leak_rate_2), .cfg_threshold_min(cfg_threshold_min),
    .cfg_leak_cycles_1(cfg_leak_cycles_1), .cfg_leak_cycles_2(cfg_leak_cycles_2),
    .ldr_load_enable(ldr_load_enable), .ldr_serial_data(ldr_serial_data),
    .ldr_params_ready(ldr_params_ready),
`ifdef PROG_VERIFY_EN
    .ldr_weight_a(ldr_weight_a), .ldr_leak_rate_1(ldr_leak_rate_1),
    .ldr_leak_rate_2(ldr_leak_rate_2), .ldr_threshold_min(ldr_threshold_min),
    .ldr_leak_cycles_1(ldr_leak_cycles_1), .ldr_leak_cycles_2(ldr_leak_cycles_2),
    .verify_err(verify_err),
`endif
    .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_accept(input logic [2:0] w, input logic [7:0] lr1, input logic [7:0] lr2,
                           input logic [7:0] th, input logic [3:0] lc1, input logic [3:0] lc2);
    cfg_weight_a = w; cfg_leak_rate_1 = lr1; cfg_leak_rate_2 = lr2;
    cfg_threshold_min = th; cfg_leak_cycles_1 = lc1; cfg_leak_cycles_2 = lc2;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if (done === 1'b1) begin n = i; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; cfg_valid = 1'b0;
    do_accept(3'd0, 8'h00, 8'h00, 8'h00, 4'd0, 4'd0);
    tick();
    reset = 1'b0;
    tick();
    checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL reset_cfg_ready got=%b exp=1", cfg_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (ldr_load_enable !== 1'b0 || ldr_serial_data !== 1'b0) begin failures++;
      $display("FAIL reset_ldr got=%b%b exp=00", ldr_load_enable, ldr_serial_data); end
    checks++; if (done !== 1'b0 || timeout_err !== 1'b0) begin failures++;
      $display("FAIL reset_done_tmo got=%b%b exp=00", done, timeout_err); end
  endtask

  task automatic test_single();
    logic [47:0] exp_s;
    int bad;
    exp_s = 48'h05A3_0128_0309;
    bad = 0;
    do_accept(3'd5, 8'hA3, 8'h01, 8'd40, 4'd3, 4'd9);
    checks++; if (ldr_load_enable !== 1'b1 || ldr_serial_data !== 1'b0 || busy !== 1'b1 || cfg_ready !== 1'b0) begin
      failures++; $display("FAIL arm_cycle got en=%b sd=%b busy=%b rdy=%b exp 1 0 1 0",
                           ldr_load_enable, ldr_serial_data, busy, cfg_ready); end
    for (int k = 0; k < 48; k++) begin
      tick();
      if (ldr_load_enable !== 1'b1 || ldr_serial_data !== exp_s[47-k]) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL serial_stream got=%0d bad_bits exp=0", bad); end
    tick();
    checks++; if (ldr_load_enable !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin failures++;
      $display("FAIL release got en=%b done=%b busy=%b exp 0 0 1", ldr_load_enable, done, busy); end
    tick();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL done_early got=%b exp=0", done); end
    tick();
    checks++; if (done !== 1'b1 || busy !== 1'b0 || cfg_ready !== 1'b1) begin failures++;
      $display("FAIL done_at_51 got done=%b busy=%b rdy=%b exp 1 0 1", done, busy, cfg_ready); end
    checks++; if ({m_field[0], m_field[1], m_field[2], m_field[3], m_field[4], m_field[5]} !== exp_s) begin failures++;
      $display("FAIL loader_fields got=%h exp=%h",
               {m_field[0], m_field[1], m_field[2], m_field[3], m_field[4], m_field[5]}, exp_s); end
    tick();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL done_pulse_width got=%b exp=0", done); end
  endtask

  task automatic test_enable_pause();
    logic en_hold, sd_hold;
    int bad, n;
    bad = 0;
    do_accept(3'd2, 8'h5C, 8'hF0, 8'h11, 4'hF, 4'h0);
    for (int i = 0; i < 10; i++) tick();
    enable = 1'b0;
    en_hold = ldr_load_enable; sd_hold = ldr_serial_data;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ldr_load_enable !== en_hold || ldr_serial_data !== sd_hold || busy !== 1'b1 || done !== 1'b0) bad++;
    end
    checks++; if (bad !== 0 || en_hold !== 1'b1) begin failures++;
      $display("FAIL pause_frozen got=%0d bad_cycles en=%b exp 0 bad en=1", bad, en_hold); end
    enable = 1'b1;
    wait_done(100, n);
    checks++; if (20 + n !== 61) begin failures++; $display("FAIL pause_latency got=%0d exp=61", 20 + n); end
    checks++; if (m_sr !== 48'h025C_F011_0F00) begin failures++;
      $display("FAIL pause_stream got=%h exp=025cf0110f00", m_sr); end
  endtask

  task automatic test_timeout();
    int seen;
    seen = 0;
    tb_hold_low = 1'b1;
    do_accept(3'd1, 8'h10, 8'h20, 8'h30, 4'd4, 4'd5);
    for (int i = 0; i < 64; i++) begin tick(); if (done === 1'b1) seen++; end
    checks++; if (timeout_err !== 1'b0 || busy !== 1'b1) begin failures++;
      $display("FAIL tmo_early got tmo=%b busy=%b exp 0 1", timeout_err, busy); end
    tick();
    checks++; if (timeout_err !== 1'b1 || busy !== 1'b0 || cfg_ready !== 1'b1) begin failures++;
      $display("FAIL tmo_set got tmo=%b busy=%b rdy=%b exp 1 0 1", timeout_err, busy, cfg_ready); end
    for (int i = 0; i < 3; i++) begin tick(); if (done === 1'b1) seen++; end
    checks++; if (seen !== 0 || timeout_err !== 1'b1) begin failures++;
      $display("FAIL tmo_sticky got done_pulses=%0d tmo=%b exp 0 1", seen, timeout_err); end
    tb_hold_low = 1'b0;
  endtask

  task automatic test_back_to_back();
    int n;
    do_accept(3'd6, 8'h77, 8'h88, 8'h99, 4'd1, 4'd2);
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL tmo_clear got=%b exp=0", timeout_err); end
    wait_done(60, n);
    checks++; if (n !== 51) begin failures++; $display("FAIL b2b_first_latency got=%0d exp=51", n); end
    do_accept(3'd1, 8'hC3, 8'h5A, 8'hE7, 4'd8, 4'd6);
    checks++; if (busy !== 1'b1 || ldr_load_enable !== 1'b1) begin failures++;
      $display("FAIL b2b_accept got busy=%b en=%b exp 1 1", busy, ldr_load_enable); end
    wait_done(60, n);
    checks++; if (n !== 51 || m_sr !== 48'h01C3_5AE7_0806) begin failures++;
      $display("FAIL b2b_second got lat=%0d stream=%h exp 51 01c35ae70806", n, m_sr); end
  endtask

  task automatic test_reset_mid();
    do_accept(3'd7, 8'h3C, 8'h42, 8'h24, 4'd2, 4'd1);
    for (int i = 0; i < 21; i++) tick();
    reset = 1'b1;
    tick();
    checks++; if (ldr_load_enable !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b1) begin failures++;
      $display("FAIL rst_mid got en=%b busy=%b rdy=%b exp 0 0 1", ldr_load_enable, busy, cfg_ready); end
    reset = 1'b0;
    tick();
    checks++; if (m_state !== 2'd0 || ldr_load_enable !== 1'b0) begin failures++;
      $display("FAIL rst_mid_loader got state=%0d en=%b exp 0 0", m_state, ldr_load_enable); end
    checks++; if (m_field[0] !== 8'h07 || m_field[1] !== 8'h3C || m_field[2] !== 8'h5A) begin failures++;
      $display("FAIL rst_mid_partial got=%h %h %h exp 07 3c 5a", m_field[0], m_field[1], m_field[2]); end
  endtask

`ifdef PROG_VERIFY_EN
  task automatic test_verify();
    int n;
    tb_corrupt = 1'b1;
    do_accept(3'd3, 8'h12, 8'h34, 8'h56, 4'd7, 4'd8);
    wait_done(60, n);
    checks++; if (n !== 51 || verify_err !== 1'b1) begin failures++;
      $display("FAIL verify_corrupt got lat=%0d verr=%b exp 51 1", n, verify_err); end
    tb_corrupt = 1'b0;
    tick();
    do_accept(3'd4, 8'hAB, 8'hCD, 8'hEF, 4'd9, 4'd10);
    checks++; if (verify_err !== 1'b0) begin failures++; $display("FAIL verify_clear got=%b exp=0", verify_err); end
    wait_done(60, n);
    checks++; if (n !== 51 || verify_err !== 1'b0) begin failures++;
      $display("FAIL verify_match got lat=%0d verr=%b exp 51 0", n, verify_err); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_enable_pause();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
`ifdef PROG_VERIFY_EN
    test_verify();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alif_param_programmer.md
Name: alif_param_programmer

Overview:
Sequencer that writes one complete dual-leak ALIF parameter set into the neuron's serial parameter loader. It accepts a parallel parameter set over a valid/ready handshake and drives the loader's load_enable / serial_data_in pins with the exact framing the loader expects: one arm cycle, then six 8-bit fields sent MSB first, then a release cycle. It then confirms params_ready and reports done or timeout. It sits between the host/config bus and the loader and shares the loader's enable.

Parameters:
FIELD_BITS, 8, bits per serial field; fixed by loader framing.
NUM_FIELDS, 6, fields per set, in order: weight_a, leak_rate_1, leak_rate_2, threshold_min, leak_cycles_1, leak_cycles_2.
READY_TIMEOUT, 15, maximum cycles in WAIT_RDY before the timeout error is raised (4-bit counter).

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  global step enable; the same net drives the loader's enable
cfg_valid  in  1  parameter set offered
cfg_ready  out  1  block can accept a set
cfg_weight_a  in  3  w_a
cfg_leak_rate_1  in  8  primary leak rate
cfg_leak_rate_2  in  8  secondary leak rate
cfg_threshold_min  in  8  minimum adaptive threshold
cfg_leak_cycles_1  in  4  primary leak period
cfg_leak_cycles_2  in  4  secondary leak period
ldr_load_enable  out  1  to loader load_enable
ldr_serial_data  out  1  to loader serial_data_in
ldr_params_ready  in  1  from loader params_ready
busy  out  1  sequence in progress
done  out  1  one-cycle pulse: set written and params_ready confirmed
timeout_err  out  1  sticky; params_ready not seen in time

Behaviour:
- Reset values: ldr_load_enable=0, ldr_serial_data=0, busy=0, done=0, timeout_err=0, state=IDLE, counters=0. cfg_ready=1 after reset.
- The whole block advances only when enable=1. With enable=0, all state, counters and outputs hold, and done is held at 0. Because the loader shares enable, the two stay aligned.
- Accept: cfg_valid & cfg_ready & enable. On accept, all six fields are latched into a 48-bit shadow shift register.
  - weight_a is zero-extended to {5'b0,w}.
  - leak_cycles fields are zero-extended to {4'b0,c}.
  - Field order is as in NUM_FIELDS, each field MSB first.
- cfg_ready = (state==IDLE). cfg_valid is ignored while busy.
- States:
  - IDLE -> ARM on accept.
  - ARM (1 cycle): ldr_load_enable=1, ldr_serial_data=0. This moves the loader from IDLE to LOAD_WA. -> SHIFT.
  - SHIFT (48 cycles): ldr_load_enable=1, ldr_serial_data = shadow MSB. Shift left and count 0..47. At count 47 -> RELEASE.
  - RELEASE (1 cycle): ldr_load_enable=0. This returns the loader from READY to IDLE. -> WAIT_RDY.
  - WAIT_RDY: if ldr_params_ready=1 -> IDLE with done=1 for one cycle. Otherwise increment the timeout counter; on reaching READY_TIMEOUT -> IDLE with timeout_err=1 and no done.
- busy=1 in every state except IDLE.
- Latency: accept cycle to done pulse is 51 enabled cycles (1 ARM + 48 SHIFT + 1 RELEASE + 1 WAIT_RDY) with a compliant loader.
- Outputs are registered. ldr_* change only on enabled clock edges.
- timeout_err clears only on reset or on the next accept.
- Reset mid-sequence: ldr_load_enable drops to 0 on the following edge. This aborts the loader to IDLE, and any fields already written stay updated in the loader.
- Back-to-back sets: a new accept is possible in the cycle after done, since cfg_ready=1 in IDLE.

Optional Feature:
PROG_VERIFY_EN.
- Present: extra inputs ldr_weight_a[2:0], ldr_leak_rate_1[7:0], ldr_leak_rate_2[7:0], ldr_threshold_min[7:0], ldr_leak_cycles_1[3:0], ldr_leak_cycles_2[3:0] (the loader's outputs), and extra output verify_err (sticky, cleared on reset or accept).
  - A second shadow copy of the accepted set is retained.
  - In WAIT_RDY, when params_ready is seen, all six loader outputs are compared with the copy. Any mismatch sets verify_err in the same cycle that done pulses.
  - done still pulses on mismatch.
- Absent: no extra ports, no second copy, behaviour otherwise identical.

Test Plan:
- Reset then idle -> cfg_ready=1, busy=0, ldr_load_enable=0, done=0, timeout_err=0.
- Send w=5, lr1=8'hA3, lr2=8'h01, thmin=8'd40, lc1=4'd3, lc2=4'd9 to a loader model -> serial stream is 00000101 10100011 00000001 00101000 00000011 00001001 after one arm cycle; done exactly 51 cycles after accept; loader outputs equal the sent values.
- Toggle enable low for 10 cycles mid-SHIFT -> ldr_* frozen, stream resumes without loss or duplication, done at 61 cycles.
- Model holds params_ready=0 -> timeout_err=1 after READY_TIMEOUT=15 WAIT_RDY cycles, no done; next accept clears timeout_err.
- Reset asserted at SHIFT count 20 -> ldr_load_enable=0 next cycle, loader returns to IDLE, cfg_ready=1.
- PROG_VERIFY_EN: model corrupts leak_rate_2 -> verify_err=1 coincident with done; matching model -> verify_err stays 0.
